// File: rtl/cmp_pkg.sv
// Shared types and the reference compare used by the comparator result tally
// and by anything that needs to know what the 2-bit comparator should output.
package cmp_pkg;

    typedef enum logic [0:0] {
        COUNT  = 1'b0,
        REPORT = 1'b1
    } state_e;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

    localparam int RUN_W = 4;

    function automatic cmp_flags_t cmp_expect(input logic [1:0] a, input logic [1:0] b);
        cmp_flags_t f;
        f.gt = (a > b);
        f.lt = (a < b);
        f.eq = (a == b);
        return f;
    endfunction

endpackage

// File: rtl/cmp_result_tally_if.sv
// Sample stream, control and snapshot report bundle of cmp_result_tally.
interface cmp_result_tally_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       A;
    logic [1:0]       B;
    logic             AgreaterB;
    logic             AlessB;
    logic             AequalB;
    logic             clear;
    logic             rpt_req;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       max_a;
    logic             eq_run_hit;

    modport master (
        output in_valid, A, B, AgreaterB, AlessB, AequalB, clear, rpt_req, rpt_ready,
        input  in_ready, rpt_valid, gt_cnt, lt_cnt, eq_cnt, err_cnt, max_a, eq_run_hit
    );

    modport slave (
        input  in_valid, A, B, AgreaterB, AlessB, AequalB, clear, rpt_req, rpt_ready,
        output in_ready, rpt_valid, gt_cnt, lt_cnt, eq_cnt, err_cnt, max_a, eq_run_hit
    );
endinterface

// File: rtl/cmp_result_tally_sat_counter.sv
// Saturating up-counter; cnt_nxt_o is the post-increment value ignoring clear,
// so a snapshot can include the sample accepted in the same cycle.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o
);
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment unless already pinned at the top value.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register; clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;
endmodule

// File: rtl/cmp_result_tally.sv
// Checks comparator flags against a local compare, tallies outcomes, tracks max A
// and equal runs, and hands out snapshots over a valid/ready report channel.
module cmp_result_tally
    import cmp_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_result_tally_if.slave bus
);
    localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(RUN_LEN - 1);
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic             in_ready_s;
    logic             rpt_valid_s;
    logic             accept_s;
    logic             go_rpt_s;
    logic             live_clr_s;
    logic             match_s;
    cmp_flags_t       flags_s;
    cmp_flags_t       exp_s;
    logic [3:0]       inc_s;
    logic [CNT_W-1:0] live_s     [4];
    logic [CNT_W-1:0] live_nxt_s [4];
    logic [CNT_W-1:0] snap_q     [4];
    logic [1:0]       max_q;
    logic [1:0]       max_d;
    logic [1:0]       max_nxt_s;
    logic [1:0]       snap_max_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             hit_q;
    logic             hit_d;

    assign flags_s    = {bus.AgreaterB, bus.AlessB, bus.AequalB};
    assign exp_s      = cmp_expect(bus.A, bus.B);
    assign match_s    = (flags_s == exp_s);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign go_rpt_s   = (state_q == COUNT) & bus.rpt_req;
    assign live_clr_s = bus.clear | go_rpt_s;

    // Index order: 0 gt, 1 lt, 2 eq, 3 err. A bad flag triple only bumps err.
    assign inc_s[0] = accept_s & match_s & exp_s.gt;
    assign inc_s[1] = accept_s & match_s & exp_s.lt;
    assign inc_s[2] = accept_s & match_s & exp_s.eq;
    assign inc_s[3] = accept_s & ~match_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: request enters REPORT, consumer handshake leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COUNT: begin
                if (bus.rpt_req) state_d = REPORT;
                else             state_d = COUNT;
            end
            REPORT: begin
                if (bus.rpt_ready) state_d = COUNT;
                else               state_d = REPORT;
            end
            default: state_d = COUNT;
        endcase
    end

    // Output decode from state only, so in_ready has no path from any input.
    always_comb begin
        in_ready_s  = 1'b0;
        rpt_valid_s = 1'b0;
        case (state_q)
            COUNT:   in_ready_s  = 1'b1;
            REPORT:  rpt_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                rpt_valid_s = 1'b0;
            end
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_i     (inc_s[g]),
            .clr_i     (live_clr_s),
            .cnt_o     (live_s[g]),
            .cnt_nxt_o (live_nxt_s[g])
        );
    end

    // Running max of A over every accepted sample, erroneous ones included.
    always_comb begin
        max_nxt_s = max_q;
        if (accept_s && (bus.A > max_q)) max_nxt_s = bus.A;
        else                             max_nxt_s = max_q;
        if (live_clr_s) max_d = 2'b00;
        else            max_d = max_nxt_s;
    end

    // Equal-run tracking; survives reports, reset only by clear or a non-equal sample.
    always_comb begin
        run_d = run_q;
        hit_d = 1'b0;
        if (bus.clear) begin
            run_d = {RUN_W{1'b0}};
        end else if (accept_s) begin
            if (inc_s[2]) begin
                if (run_q != RUN_TOP) run_d = run_q + RUN_ONE;
                else                  run_d = run_q;
                hit_d = (run_q == RUN_PRE);
            end else begin
                run_d = {RUN_W{1'b0}};
            end
        end else begin
            run_d = run_q;
        end
    end

    // Live max, run counter and hit pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q <= 2'b00;
            run_q <= {RUN_W{1'b0}};
            hit_q <= 1'b0;
        end else begin
            max_q <= max_d;
            run_q <= run_d;
            hit_q <= hit_d;
        end
    end

    // Snapshot capture on entry to REPORT, held stable until the next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) snap_q[i] <= {CNT_W{1'b0}};
            snap_max_q <= 2'b00;
        end else if (go_rpt_s) begin
            for (int i = 0; i < 4; i++) snap_q[i] <= live_nxt_s[i];
            snap_max_q <= max_nxt_s;
        end else begin
            for (int i = 0; i < 4; i++) snap_q[i] <= snap_q[i];
            snap_max_q <= snap_max_q;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.rpt_valid  = rpt_valid_s;
    assign bus.gt_cnt     = snap_q[0];
    assign bus.lt_cnt     = snap_q[1];
    assign bus.eq_cnt     = snap_q[2];
    assign bus.err_cnt    = snap_q[3];
    assign bus.max_a      = snap_max_q;
    assign bus.eq_run_hit = hit_q;
endmodule
